// File: rtl/pulse_gate_counter_if.sv
// Bus between the gate/sensor source and the pulse_gate_counter result outputs.
interface pulse_gate_counter_if #(
  parameter int CNT_W  = 14,
  parameter int DIGITS = 4
);
  logic                  gate;
  logic                  sensor;
  logic [CNT_W-1:0]      count_out;
  logic [4*DIGITS-1:0]   bcd_out;
  logic                  valid;
  logic                  overflow;

  modport master (
    output gate, sensor,
    input  count_out, bcd_out, valid, overflow
  );

  modport slave (
    input  gate, sensor,
    output count_out, bcd_out, valid, overflow
  );
endinterface

// File: rtl/pulse_gate_counter.sv
// Gated wheel-pulse counter: debounced edge counting per gate-high window,
// result latched on gate fall and converted to BCD by a sequential shift-add-3.
module pulse_gate_counter #(
  parameter int CNT_W        = 14,
  parameter int MAX_COUNT    = 9999,
  parameter int DIGITS       = 4,
  parameter int DEBOUNCE_CYC = 50000
) (
  input logic                  clock,
  input logic                  reset,
  pulse_gate_counter_if.slave  bus
);

  localparam int DW = (DEBOUNCE_CYC > 1) ? $clog2(DEBOUNCE_CYC) : 1;
  localparam int IW = $clog2(CNT_W + 1);
  localparam int BW = 4 * DIGITS;

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_CONV = 2'd1;
  localparam logic [1:0] S_DONE = 2'd2;

  logic          sync1, sync2;
  logic          deb, deb_q;
  logic [DW-1:0] deb_cnt;
  logic          ev;

  logic             gate_d;
  logic             rise, fall;
  logic [CNT_W-1:0] acc;
  logic             acc_ovf;
  logic             acc_at_max;
  logic [CNT_W-1:0] lat_val;
  logic             lat_ovf;

  logic [1:0]       state;
  logic [IW-1:0]    iter;
  logic [CNT_W-1:0] shreg;
  logic [BW-1:0]    bcd_sc;
  logic [BW-1:0]    bcd_adj;
  logic [CNT_W-1:0] res_val;
  logic             res_ovf;

  // Sensor synchronizer and debounce filter
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      sync1   <= 1'b0;
      sync2   <= 1'b0;
      deb     <= 1'b0;
      deb_q   <= 1'b0;
      deb_cnt <= '0;
    end else begin
      sync1 <= bus.sensor;
      sync2 <= sync1;
      deb_q <= deb;
      if (sync2 != deb) begin
        if (deb_cnt == DW'(DEBOUNCE_CYC - 1)) begin
          deb     <= sync2;
          deb_cnt <= '0;
        end else begin
          deb_cnt <= deb_cnt + 1'b1;
        end
      end else begin
        deb_cnt <= '0;
      end
    end
  end

  assign ev   = deb & ~deb_q;
  assign rise = bus.gate & ~gate_d;
  assign fall = ~bus.gate & gate_d;

  assign acc_at_max = (acc == CNT_W'(MAX_COUNT));
  assign lat_val    = (ev && !acc_at_max) ? acc + 1'b1 : acc;
  assign lat_ovf    = acc_ovf | (ev & acc_at_max);

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      gate_d  <= 1'b0;
      acc     <= '0;
      acc_ovf <= 1'b0;
    end else begin
      gate_d <= bus.gate;
      if (rise) begin
        acc     <= '0;
        acc_ovf <= 1'b0;
      end else if (bus.gate && ev) begin
        if (acc_at_max) acc_ovf <= 1'b1;
        else            acc     <= acc + 1'b1;
      end
    end
  end

  always_comb begin
    bcd_adj = bcd_sc;
    for (int unsigned i = 0; i < DIGITS; i++) begin
      if (bcd_sc[4*i +: 4] >= 4'd5)
        bcd_adj[4*i +: 4] = bcd_sc[4*i +: 4] + 4'd3;
    end
  end

  // Conversion engine; a window that closes while busy is discarded
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state         <= S_IDLE;
      iter          <= '0;
      shreg         <= '0;
      bcd_sc        <= '0;
      res_val       <= '0;
      res_ovf       <= 1'b0;
      bus.count_out <= '0;
      bus.bcd_out   <= '0;
      bus.overflow  <= 1'b0;
      bus.valid     <= 1'b0;
    end else begin
      bus.valid <= 1'b0;
      case (state)
        S_IDLE: begin
          if (fall) begin
            shreg   <= lat_val;
            res_val <= lat_val;
            res_ovf <= lat_ovf;
            bcd_sc  <= '0;
            iter    <= '0;
            state   <= S_CONV;
          end
        end
        S_CONV: begin
          {bcd_sc, shreg} <= {bcd_adj, shreg} << 1;
          iter            <= iter + 1'b1;
          if (iter == IW'(CNT_W - 1)) state <= S_DONE;
        end
        S_DONE: begin
          bus.count_out <= res_val;
          bus.bcd_out   <= bcd_sc;
          bus.overflow  <= res_ovf;
          bus.valid     <= 1'b1;
          state         <= S_IDLE;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: doc/pulse_gate_counter.md
Name: pulse_gate_counter

Overview:
Counts debounced rising edges of the wheel-sensor input during each high phase of the slow gate square wave from the seconds clock divider. Each window's result is latched on the gate falling edge. The block then converts the result to BCD with a sequential shift-add-3 engine. It presents count, BCD digits, overflow and a one-cycle valid strobe to the downstream display driver of the speedometer.

Parameters:
CNT_W, 14, width of the pulse accumulator and binary result.
MAX_COUNT, 9999, saturation value; must be < 2^CNT_W and <= 10^DIGITS-1.
DIGITS, 4, number of BCD digits produced.
DEBOUNCE_CYC, 50000, consecutive stable clock cycles required before a new sensor level is accepted (>=1).

Ports:
clock  in  1  system clock; all logic on its rising edge
reset  in  1  asynchronous, active-high reset
gate  in  1  measurement window from the seconds divider; same clock domain; counting while high
sensor  in  1  raw wheel sensor; asynchronous, may bounce
count_out  out  CNT_W  binary pulse count of last completed window
bcd_out  out  4*DIGITS  BCD of count_out; digit 0 (units) in bits [3:0]
valid  out  1  one-cycle strobe when count_out/bcd_out/overflow update
overflow  out  1  last completed window reached MAX_COUNT saturation

Behaviour:
- Reset (async, active-high) sets count_out=0, bcd_out=0, valid=0, overflow=0, accumulator=0, sticky overflow=0, gate_d=0, synchronizer and debounced level=0, debounce counter=0, FSM=IDLE. Reset asserted mid-conversion aborts it; no valid is issued.
- Sensor path: 2-FF synchronizer, then debounce. The debounced level changes only after the synchronized input differs from it for DEBOUNCE_CYC consecutive cycles. Any return to equality clears the debounce counter. An event is a one-cycle pulse on a 0->1 transition of the debounced level.
- Gate edges: gate_d is gate registered. Rise = gate & ~gate_d; fall = ~gate & gate_d. Because gate_d resets to 0, gate high at reset release is treated as a rise.
- On rise: accumulator <= 0 and sticky overflow <= 0. An event in the same cycle is not counted.
- Gate high (not the rise cycle): on each event, accumulator += 1, saturating at MAX_COUNT. An event arriving while the accumulator equals MAX_COUNT sets sticky overflow.
- Fall handling:
  - An event in the fall cycle is counted: latched = sat(acc + event). Overflow is updated the same way.
  - If FSM=IDLE, load the shift register with the latched value, clear the BCD scratch, store the overflow flag, and go to CONVERT.
  - If FSM is not IDLE, the window is dropped silently.
- Accumulator runs independently of the FSM. A new window may start while a conversion is in progress.
- FSM:
  - IDLE: waits for fall.
  - CONVERT: CNT_W iterations, one per cycle. Each iteration adds 3 to every BCD digit >=5, then shifts {bcd, bin} left by 1. An iteration counter tracks progress; after the CNT_W-th iteration go to DONE.
  - DONE: for one cycle, count_out <= latched value, bcd_out <= scratch, overflow <= stored flag, valid <= 1; next state IDLE.
- Latency: if fall is detected at edge N, iterations occur at edges N+1..N+CNT_W. Outputs update and valid goes high at edge N+CNT_W+1; valid drops at N+CNT_W+2.
- Outputs hold their values between valid strobes. valid is never high on two consecutive cycles.
- Gate low with no prior rise: the accumulator holds 0 and events are ignored.

Test Plan:
- Reset with gate=0 and DEBOUNCE_CYC=4 -> all outputs 0; no valid for 100 cycles.
- 37 clean sensor pulses (8 high / 8 low cycles each) inside one gate-high window, then gate falls at edge N -> valid exactly at N+15 (CNT_W=14), count_out=37, bcd_out=16'h0037, overflow=0.
- Sensor glitches of 1-3 cycles mixed with 5 valid pulses -> count_out=5, bcd_out=16'h0005.
- 10050 pulses in one window -> count_out=9999, bcd_out=16'h9999, overflow=1. Next window with 12 pulses -> count_out=12, overflow=0.
- Second gate window of 3 cycles starting and ending during CONVERT -> that window dropped. First result reported correctly; a single valid.
- Reset asserted 5 cycles after fall -> no valid; outputs 0. The following 21-pulse window reports count_out=21, bcd_out=16'h0021.
